// File: rtl/axi_regfile_pkg.sv
// Shared types for the AXI4-Lite register file: response codes, FSM states and address decode.
package axi_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  typedef enum logic [1:0] {REG_CTRL, REG_STAT, REG_COMMIT, REG_NONE} region_e;

  typedef struct packed {
    region_e     region;
    logic [31:0] idx;
  } dec_t;

  // word is the byte address shifted right by 2; idx is local to the region
  function automatic dec_t addr_decode(input logic [31:0] word,
                                       input logic [31:0] num_ctrl,
                                       input logic [31:0] num_stat,
                                       input logic [31:0] commit_word,
                                       input logic        commit_en);
    dec_t d;
    d.region = REG_NONE;
    d.idx    = '0;
    if (word < num_ctrl) begin
      d.region = REG_CTRL;
      d.idx    = word;
    end else if (word < num_ctrl + num_stat) begin
      d.region = REG_STAT;
      d.idx    = word - num_ctrl;
    end else if (commit_en && (word == commit_word)) begin
      d.region = REG_COMMIT;
    end
    return d;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite channel bundle; master drives requests, slave drives responses.
interface axi_lite_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_regfile_strb_merge.sv
// Combinational byte-lane merge: lane b takes wdata when wstrb[b] is set, else keeps old value.
module axi_regfile_strb_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] new_o
);
  always_comb begin
    new_o = old_i;
    for (int b = 0; b < 4; b++) begin
      if (wstrb_i[b]) new_o[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end
endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave with NUM_CTRL r/w control regs and NUM_STAT status words; B/R one cycle after the write/AR edge.
// AXI_REGFILE_SHADOW_EN: control writes land in a dirty-tracked shadow and are applied by a COMMIT write.
module axi_lite_regfile
  import axi_regfile_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_CTRL           = 32,
  parameter int NUM_STAT           = 16
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_areset,
  axi_lite_regfile_if.slave        s_axi,
  output logic [NUM_CTRL*32-1:0]   ctrl_regs,
  output logic [NUM_CTRL-1:0]      ctrl_wr_pulse,
  input  logic [NUM_STAT*32-1:0]   stat_regs
);
  localparam logic [31:0] COMMIT_WORD = 32'(2**(C_S_AXI_ADDR_WIDTH-2) - 1);
`ifdef AXI_REGFILE_SHADOW_EN
  localparam logic COMMIT_EN = 1'b1;
`else
  localparam logic COMMIT_EN = 1'b0;
`endif

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("axi_lite_regfile: C_S_AXI_DATA_WIDTH must be 32");
  end
  if (NUM_CTRL + NUM_STAT + 1 > 2**(C_S_AXI_ADDR_WIDTH-2)) begin : g_bad_map
    $error("axi_lite_regfile: register map does not fit the address space");
  end

  wstate_e wstate_q;
  rstate_e rstate_q;
  logic aw_held_q, w_held_q, awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0] bresp_q, rresp_q;
  logic [31:0] rdata_q, w_data_q;
  logic [3:0] w_strb_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0] ctrl_q [NUM_CTRL];
  logic [31:0] view [NUM_CTRL];
  logic [NUM_CTRL-1:0] pulse_q;
`ifdef AXI_REGFILE_SHADOW_EN
  logic [31:0] shadow_q [NUM_CTRL];
  logic [NUM_CTRL-1:0] dirty_q;
`endif

  logic aw_hs, w_hs, ar_hs, do_write;
  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr;
  logic [31:0] wdata, wold, wnew, rdata_d;
  logic [3:0] wstrb;
  logic [1:0] wresp_d, rresp_d;
  dec_t wdec, rdec;

  // The readable/mergeable copy of a control register is the shadow when shadowing is on
  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
`ifdef AXI_REGFILE_SHADOW_EN
    assign view[g] = shadow_q[g];
`else
    assign view[g] = ctrl_q[g];
`endif
    assign ctrl_regs[g*32 +: 32] = ctrl_q[g];
  end
  assign ctrl_wr_pulse = pulse_q;

  assign aw_hs    = s_axi.awvalid && awready_q;
  assign w_hs     = s_axi.wvalid && wready_q;
  assign ar_hs    = s_axi.arvalid && arready_q;
  assign waddr    = aw_held_q ? aw_addr_q : s_axi.awaddr;
  assign wdata    = w_held_q ? w_data_q : s_axi.wdata;
  assign wstrb    = w_held_q ? w_strb_q : s_axi.wstrb;
  assign do_write = (wstate_q == W_IDLE) && (aw_hs || aw_held_q) && (w_hs || w_held_q);
  assign wdec = addr_decode(32'(waddr[C_S_AXI_ADDR_WIDTH-1:2]), 32'(NUM_CTRL), 32'(NUM_STAT),
                            COMMIT_WORD, COMMIT_EN);
  assign rdec = addr_decode(32'(s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]), 32'(NUM_CTRL), 32'(NUM_STAT),
                            COMMIT_WORD, COMMIT_EN);

  always_comb begin
    wold = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (wdec.idx == 32'(i)) wold = view[i];
    end
    case (wdec.region)
      REG_CTRL, REG_COMMIT: wresp_d = RESP_OKAY;
      REG_STAT:             wresp_d = RESP_SLVERR;
      default:              wresp_d = RESP_DECERR;
    endcase
  end

  axi_regfile_strb_merge u_strb_merge (
    .old_i   (wold),
    .wdata_i (wdata),
    .wstrb_i (wstrb),
    .new_o   (wnew)
  );

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (do_write) begin
            wstate_q  <= W_RESP;
            aw_held_q <= 1'b1;
            w_held_q  <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wresp_d;
          end else begin
            aw_held_q <= aw_held_q || aw_hs;
            w_held_q  <= w_held_q || w_hs;
            awready_q <= !(aw_held_q || aw_hs);
            wready_q  <= !(w_held_q || w_hs);
            if (aw_hs) aw_addr_q <= s_axi.awaddr;
            if (w_hs) begin
              w_data_q <= s_axi.wdata;
              w_strb_q <= s_axi.wstrb;
            end
          end
        end
        default: begin
          if (s_axi.bready) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
      pulse_q <= '0;
`ifdef AXI_REGFILE_SHADOW_EN
      for (int i = 0; i < NUM_CTRL; i++) shadow_q[i] <= '0;
      dirty_q <= '0;
`endif
    end else begin
      pulse_q <= '0;
      if (do_write) begin
`ifdef AXI_REGFILE_SHADOW_EN
        if (wdec.region == REG_CTRL && wstrb != 4'b0) begin
          for (int i = 0; i < NUM_CTRL; i++) begin
            if (wdec.idx == 32'(i)) begin
              shadow_q[i] <= wnew;
              dirty_q[i]  <= 1'b1;
            end
          end
        end else if (wdec.region == REG_COMMIT && wstrb[0] && wdata[0]) begin
          for (int i = 0; i < NUM_CTRL; i++) begin
            if (dirty_q[i]) ctrl_q[i] <= shadow_q[i];
          end
          pulse_q <= dirty_q;
          dirty_q <= '0;
        end
`else
        if (wdec.region == REG_CTRL && wstrb != 4'b0) begin
          for (int i = 0; i < NUM_CTRL; i++) begin
            if (wdec.idx == 32'(i)) begin
              ctrl_q[i]  <= wnew;
              pulse_q[i] <= 1'b1;
            end
          end
        end
`endif
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_DECERR;
    case (rdec.region)
      REG_CTRL: begin
        rresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (rdec.idx == 32'(i)) rdata_d = view[i];
        end
      end
      REG_STAT: begin
        rresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_STAT; i++) begin
          if (rdec.idx == 32'(i)) rdata_d = stat_regs[i*32 +: 32];
        end
      end
`ifdef AXI_REGFILE_SHADOW_EN
      REG_COMMIT: begin
        rresp_d = RESP_OKAY;
        rdata_d = {31'b0, |dirty_q};
      end
`endif
      default: ;
    endcase
  end

  // Read data is sampled on the AR edge, so a same-edge write is seen as its pre-write value
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            rstate_q  <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
          end else begin
            arready_q <= 1'b1;
          end
        end
        default: begin
          if (s_axi.rready) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, waddr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (default parameters); AXI_REGFILE_SHADOW_EN selects the shadow/commit scenario.
module tb_axi_lite_regfile;
  import axi_regfile_pkg::*;

`ifdef AXI_REGFILE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [1023:0]   ctrl_regs;
  logic [31:0]     ctrl_wr_pulse;
  logic [511:0]    stat_regs;
  int vectors = 0;
  int miscompares = 0;

  axi_lite_regfile_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  axi_lite_regfile #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (8),
    .NUM_CTRL           (32),
    .NUM_STAT           (16)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .s_axi         (bus),
    .ctrl_regs     (ctrl_regs),
    .ctrl_wr_pulse (ctrl_wr_pulse),
    .stat_regs     (stat_regs)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] creg(input int i);
    return ctrl_regs[i*32 +: 32];
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [31:0] pulses);
    logic aw_go, w_go;
    int n;
    pulses = '0;
    resp = 2'bxx;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      tick();
      n++;
      pulses |= ctrl_wr_pulse;
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go) bus.wvalid = 1'b0;
    end
    n = 0;
    while (!bus.bvalid && n < 50) begin
      tick();
      pulses |= ctrl_wr_pulse;
      n++;
    end
    if (!bus.bvalid) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout addr=%h: no B response within bound", a);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end else begin
      resp = bus.bresp;
      tick();
      pulses |= ctrl_wr_pulse;
    end
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] data, output logic [1:0] resp);
    int n;
    data = 'x;
    resp = 2'bxx;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin tick(); n++; end
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 50) begin tick(); n++; end
    if (!bus.rvalid) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout addr=%h: no R response within bound", a);
    end else begin
      data = bus.rdata;
      resp = bus.rresp;
      tick();
    end
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    stat_regs = '0;
    repeat (3) tick();
    vectors++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_readies: got %b expected 000", {bus.awready, bus.wready, bus.arready});
    end
    vectors++;
    if ({ctrl_regs, ctrl_wr_pulse} !== '0) begin
      miscompares++; $display("FAIL reset_ctrl: got regs|pulse nonzero, pulse=%h expected 0", ctrl_wr_pulse);
    end
    vectors++;
    if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata} !== '0) begin
      miscompares++; $display("FAIL reset_resp: got bv=%b rv=%b br=%b rr=%b rd=%h expected all 0",
                              bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      miscompares++; $display("FAIL release_readies: got %b expected 111", {bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_same_cycle();
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    vectors++;
    if (creg(1) !== (SHADOW ? 32'h0 : 32'hDEADBEEF)) begin
      miscompares++; $display("FAIL same_cycle_reg1: got %h expected %h", creg(1), SHADOW ? 32'h0 : 32'hDEADBEEF);
    end
    vectors++;
    if (ctrl_wr_pulse !== (SHADOW ? 32'h0 : 32'h2)) begin
      miscompares++; $display("FAIL same_cycle_pulse: got %h expected %h", ctrl_wr_pulse, SHADOW ? 32'h0 : 32'h2);
    end
    vectors++;
    if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== {1'b1, RESP_OKAY, 2'b00}) begin
      miscompares++; $display("FAIL same_cycle_b: got bv=%b br=%b aw/w rdy=%b%b expected 1 00 00",
                              bus.bvalid, bus.bresp, bus.awready, bus.wready);
    end
    tick();
    bus.bready = 1'b0;
    vectors++;
    if ({bus.bvalid, ctrl_wr_pulse, bus.awready, bus.wready} !== {1'b0, 32'h0, 2'b11}) begin
      miscompares++; $display("FAIL same_cycle_after: got bv=%b pulse=%h rdy=%b%b expected 0 0 11",
                              bus.bvalid, ctrl_wr_pulse, bus.awready, bus.wready);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] resp;
    logic [31:0] ps, rd;
    do_write(8'h00, 32'hAAAAAAAA, 4'hF, resp, ps);
    bus.wdata = 32'h11223344; bus.wstrb = 4'h5; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    vectors++;
    if ({bus.wready, bus.awready} !== 2'b01) begin
      miscompares++; $display("FAIL w_first_held: got wrdy/awrdy=%b expected 01", {bus.wready, bus.awready});
    end
    tick(); tick();
    vectors++;
    if ({bus.wready, bus.bvalid} !== 2'b00) begin
      miscompares++; $display("FAIL w_first_wait: got wrdy/bv=%b expected 00", {bus.wready, bus.bvalid});
    end
    bus.awaddr = 8'h00; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    vectors++;
    if ({bus.bvalid, bus.wready, creg(0)} !== {2'b10, (SHADOW ? 32'hAAAAAAAA : 32'hAA22AA44)}) begin
      miscompares++; $display("FAIL w_first_commit: got bv=%b wrdy=%b reg0=%h expected 1 0 %h",
                              bus.bvalid, bus.wready, creg(0), SHADOW ? 32'hAAAAAAAA : 32'hAA22AA44);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    vectors++;
    if (bus.wready !== 1'b1) begin
      miscompares++; $display("FAIL w_first_reopen: got wready=%b expected 1", bus.wready);
    end
    do_read(8'h00, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'hAA22AA44, RESP_OKAY}) begin
      miscompares++; $display("FAIL w_first_readback: got %h/%b expected aa22aa44/00", rd, resp);
    end
  endtask

  task automatic test_status_read();
    logic [31:0] rd;
    logic [1:0] resp;
    stat_regs[31:0] = 32'h0BADF00D;
    stat_regs[511:480] = 32'hCAFE0015;
    bus.araddr = 8'h80; bus.arvalid = 1'b1; bus.rready = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    stat_regs[31:0] = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if ({bus.rvalid, bus.rdata, bus.rresp} !== {1'b1, 32'h0BADF00D, RESP_OKAY}) begin
        miscompares++; $display("FAIL stat_hold[%0d]: got rv=%b rd=%h rr=%b expected 1 0badf00d 00",
                                c, bus.rvalid, bus.rdata, bus.rresp);
      end
      tick();
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    vectors++;
    if ({bus.rvalid, bus.arready} !== 2'b01) begin
      miscompares++; $display("FAIL stat_release: got rv/arrdy=%b expected 01", {bus.rvalid, bus.arready});
    end
    do_read(8'hBC, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'hCAFE0015, RESP_OKAY}) begin
      miscompares++; $display("FAIL stat_last: got %h/%b expected cafe0015/00", rd, resp);
    end
    do_read(8'hC0, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'h0, RESP_DECERR}) begin
      miscompares++; $display("FAIL past_stat: got %h/%b expected 0/11", rd, resp);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [31:0] ps, rd;
    do_write(8'h84, 32'hFFFFFFFF, 4'hF, resp, ps);
    vectors++;
    if ({resp, ps} !== {RESP_SLVERR, 32'h0}) begin
      miscompares++; $display("FAIL stat_write: got resp=%b pulses=%h expected 10 0", resp, ps);
    end
    do_read(8'hF0, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'h0, RESP_DECERR}) begin
      miscompares++; $display("FAIL decerr_read: got %h/%b expected 0/11", rd, resp);
    end
    do_write(8'hF0, 32'h5A5A5A5A, 4'hF, resp, ps);
    vectors++;
    if ({resp, ps} !== {RESP_DECERR, 32'h0}) begin
      miscompares++; $display("FAIL decerr_write: got resp=%b pulses=%h expected 11 0", resp, ps);
    end
    do_write(8'h04, 32'h0, 4'h0, resp, ps);
    vectors++;
    if ({resp, ps} !== {RESP_OKAY, 32'h0}) begin
      miscompares++; $display("FAIL zero_strb: got resp=%b pulses=%h expected 00 0", resp, ps);
    end
    do_read(8'h07, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'hDEADBEEF, RESP_OKAY}) begin
      miscompares++; $display("FAIL zero_strb_keep: got %h/%b expected deadbeef/00", rd, resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [1:0] resp;
    bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'h33; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    tick();
    bus.awaddr = 8'h10; bus.wdata = 32'h44;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({bus.bvalid, bus.awready, bus.wready, creg(4)} !== {3'b100, 32'h0}) begin
        miscompares++; $display("FAIL b2b_stall[%0d]: got bv=%b rdy=%b%b reg4=%h expected 1 00 0",
                                c, bus.bvalid, bus.awready, bus.wready, creg(4));
      end
      tick();
    end
    bus.bready = 1'b1;
    tick();
    vectors++;
    if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
      miscompares++; $display("FAIL b2b_handoff: got bv=%b rdy=%b%b expected 0 11", bus.bvalid, bus.awready, bus.wready);
    end
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    vectors++;
    if ({bus.bvalid, ctrl_wr_pulse, creg(4)} !== {1'b1, (SHADOW ? 32'h0 : 32'h10), (SHADOW ? 32'h0 : 32'h44)}) begin
      miscompares++; $display("FAIL b2b_second: got bv=%b pulse=%h reg4=%h", bus.bvalid, ctrl_wr_pulse, creg(4));
    end
    tick();
    bus.bready = 1'b0;
    do_read(8'h0C, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'h33, RESP_OKAY}) begin
      miscompares++; $display("FAIL b2b_first_rb: got %h/%b expected 33/00", rd, resp);
    end
    do_read(8'h10, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'h44, RESP_OKAY}) begin
      miscompares++; $display("FAIL b2b_second_rb: got %h/%b expected 44/00", rd, resp);
    end
  endtask

`ifdef AXI_REGFILE_SHADOW_EN
  task automatic test_shadow();
    logic [1:0] resp;
    logic [31:0] ps, rd;
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    do_write(8'h08, 32'h5, 4'hF, resp, ps);
    do_write(8'h1C, 32'h9, 4'hF, resp, ps);
    vectors++;
    if ({creg(2), creg(7), ps} !== {32'h0, 32'h0, 32'h0}) begin
      miscompares++; $display("FAIL shadow_hold: got reg2=%h reg7=%h pulses=%h expected 0 0 0", creg(2), creg(7), ps);
    end
    do_read(8'hFC, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'h1, RESP_OKAY}) begin
      miscompares++; $display("FAIL commit_dirty: got %h/%b expected 1/00", rd, resp);
    end
    do_read(8'h08, rd, resp);
    vectors++;
    if (rd !== 32'h5) begin
      miscompares++; $display("FAIL shadow_read: got %h expected 5", rd);
    end
    do_write(8'hFC, 32'h1, 4'h1, resp, ps);
    vectors++;
    if ({resp, ps, creg(2), creg(7)} !== {RESP_OKAY, 32'h84, 32'h5, 32'h9}) begin
      miscompares++; $display("FAIL commit: got resp=%b pulses=%h reg2=%h reg7=%h expected 00 84 5 9",
                              resp, ps, creg(2), creg(7));
    end
    do_read(8'hFC, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'h0, RESP_OKAY}) begin
      miscompares++; $display("FAIL commit_clean: got %h/%b expected 0/00", rd, resp);
    end
  endtask
`else
  task automatic test_commit_decerr();
    logic [1:0] resp;
    logic [31:0] ps, rd;
    do_write(8'hFC, 32'h1, 4'hF, resp, ps);
    vectors++;
    if ({resp, ps} !== {RESP_DECERR, 32'h0}) begin
      miscompares++; $display("FAIL commit_wr_decerr: got resp=%b pulses=%h expected 11 0", resp, ps);
    end
    do_read(8'hFC, rd, resp);
    vectors++;
    if ({rd, resp} !== {32'h0, RESP_DECERR}) begin
      miscompares++; $display("FAIL commit_rd_decerr: got %h/%b expected 0/11", rd, resp);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [1:0] resp;
    logic [31:0] rd;
    bus.awaddr = 8'h08; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    vectors++;
    if (bus.awready !== 1'b0) begin
      miscompares++; $display("FAIL mid_aw_held: got awready=%b expected 0", bus.awready);
    end
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    tick(); tick();
    vectors++;
    if ({bus.bvalid, bus.awready} !== 2'b01) begin
      miscompares++; $display("FAIL mid_discard: got bv=%b awrdy=%b expected 0 1", bus.bvalid, bus.awready);
    end
    bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    vectors++;
    if ({bus.bvalid, bus.bresp} !== {1'b1, RESP_OKAY}) begin
      miscompares++; $display("FAIL mid_complete: got bv=%b br=%b expected 1 00", bus.bvalid, bus.bresp);
    end
    tick();
    bus.bready = 1'b0;
    do_read(8'h0C, rd, resp);
    vectors++;
    if (rd !== 32'h77) begin
      miscompares++; $display("FAIL mid_reg3: got %h expected 77", rd);
    end
    do_read(8'h08, rd, resp);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("FAIL mid_reg2: got %h expected 0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_status_read();
    test_errors();
    test_back_to_back();
`ifdef AXI_REGFILE_SHADOW_EN
    test_shadow();
`else
    test_commit_decerr();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
